// File: rtl/test_runner_pkg.sv
// Shared types and width helpers for the test_runner sequencing harness.
package test_runner_pkg;

  typedef enum logic [1:0] {HOLD, RUN, NEXT, DONE} state_e;

  // Index width for cur_test; a single test still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/test_runner_cnt.sv
// Clearable up-counter that stops at TC and flags it; clear has priority over count.
module test_runner_cnt #(
  parameter int W  = 4,
  parameter int TC = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == W'(TC));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)             cnt_d = '0;
    else if (en_i && !tc_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/test_runner.sv
// Runs attached self-checking tests one at a time and aggregates their results.
// Optional per-test RUN timeout is enabled by defining TEST_RUNNER_TIMEOUT_EN.
module test_runner
  import test_runner_pkg::*;
#(
  parameter int  NUM_TESTS    = 4,
  parameter int  RESET_CYCLES = 2,
  parameter int  TIMEOUT      = 1000,
  localparam int IDX_W        = idx_w(NUM_TESTS),
  localparam int CNT_W        = cnt_w(NUM_TESTS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_TESTS-1:0] test_fail,
  input  logic [NUM_TESTS-1:0] test_finish,
  output logic [NUM_TESTS-1:0] test_reset,
  output logic [IDX_W-1:0]     cur_test,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [CNT_W-1:0]     fail_count,
  output logic [NUM_TESTS-1:0] timeout_mask,
  output logic                 done,
  output logic                 fail
);

  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

  if (NUM_TESTS < 1 || RESET_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("test_runner: NUM_TESTS, RESET_CYCLES and TIMEOUT must all be >= 1");
  end

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [NUM_TESTS-1:0] fmask_q, fmask_d;
  logic [CNT_W-1:0]     fcnt_q, fcnt_d;
  logic [NUM_TESTS-1:0] trst_q, trst_d;
  logic                 hold_tc;

  test_runner_cnt #(.W(HOLD_W), .TC(RESET_CYCLES - 1)) u_hold_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (state_q != HOLD),
    .en_i  (state_q == HOLD),
    .tc_o  (hold_tc)
  );

`ifdef TEST_RUNNER_TIMEOUT_EN
  localparam int RUN_W = $clog2(TIMEOUT + 1);

  logic [NUM_TESTS-1:0] tmask_q, tmask_d;
  logic                 run_tc;

  test_runner_cnt #(.W(RUN_W), .TC(TIMEOUT - 1)) u_run_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (state_q != RUN),
    .en_i  (state_q == RUN),
    .tc_o  (run_tc)
  );

  assign timeout_mask = tmask_q;
`else
  assign timeout_mask = '0;
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    fmask_d = fmask_q;
    fcnt_d  = fcnt_q;
`ifdef TEST_RUNNER_TIMEOUT_EN
    tmask_d = tmask_q;
`endif
    case (state_q)
      HOLD: if (hold_tc) state_d = RUN;
      RUN: begin
        if (test_fail[cur_q]) fmask_d[cur_q] = 1'b1;
        // A finish arriving on the timeout cycle takes precedence over the timeout.
        if (test_finish[cur_q]) begin
          state_d = NEXT;
        end
`ifdef TEST_RUNNER_TIMEOUT_EN
        else if (run_tc) begin
          tmask_d[cur_q] = 1'b1;
          fmask_d[cur_q] = 1'b1;
          state_d        = NEXT;
        end
`endif
      end
      NEXT: begin
        if (fmask_q[cur_q]) fcnt_d = fcnt_q + CNT_W'(1);
        if (cur_q == IDX_W'(NUM_TESTS - 1)) begin
          state_d = DONE;
        end else begin
          cur_d   = cur_q + IDX_W'(1);
          state_d = HOLD;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = HOLD;
    endcase

    // Selected test is out of reset from the HOLD->RUN edge until the edge leaving NEXT.
    trst_d = '1;
    if (state_q == RUN || state_d == RUN) trst_d[cur_q] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HOLD;
      cur_q   <= '0;
      fmask_q <= '0;
      fcnt_q  <= '0;
      trst_q  <= '1;
`ifdef TEST_RUNNER_TIMEOUT_EN
      tmask_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      fmask_q <= fmask_d;
      fcnt_q  <= fcnt_d;
      trst_q  <= trst_d;
`ifdef TEST_RUNNER_TIMEOUT_EN
      tmask_q <= tmask_d;
`endif
    end
  end

  assign test_reset = trst_q;
  assign cur_test   = cur_q;
  assign fail_mask  = fmask_q;
  assign fail_count = fcnt_q;
  assign done       = (state_q == DONE);
  assign fail       = done && (fcnt_q != '0);

endmodule

// File: tb/tb_test_runner.sv
// Self-checking bench for test_runner: mock unit tests plus a run-length scoreboard.
module tb_test_runner;

  localparam int N  = 4;
  localparam int RC = 2;
  localparam int TO = 20;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] t_fail, t_finish, t_reset, fail_mask, timeout_mask;
  logic [1:0]   cur_test;
  logic [2:0]   fail_count;
  logic         done, fail;

  always #5 clock = ~clock;

  test_runner #(.NUM_TESTS(N), .RESET_CYCLES(RC), .TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .test_fail    (t_fail),
    .test_finish  (t_finish),
    .test_reset   (t_reset),
    .cur_test     (cur_test),
    .fail_mask    (fail_mask),
    .fail_count   (fail_count),
    .timeout_mask (timeout_mask),
    .done         (done),
    .fail         (fail)
  );

  typedef struct {int idx; int len;} rec_t;

  rec_t         exp_q[$];
  rec_t         obs_q[$];
  int           errors = 0;
  int           checks = 0;
  int           fin_at[N];  // mock count at which finish fires; -1 never
  int           fmode[N];   // 0 pass, 1 fail with finish, 2 fail pulse 3 cycles before finish
  int           mcnt[N];
  int           lowcnt[N];
  logic [N-1:0] spur_fin  = '0;
  logic [N-1:0] spur_fail = '0;
  bit           mon_en    = 0;
  bit           multi_low = 0;

  // Mock tests: count cycles since release, driven only while out of reset.
  always @(posedge clock)
    for (int i = 0; i < N; i++) mcnt[i] <= t_reset[i] ? 0 : mcnt[i] + 1;

  always_comb begin
    t_finish = '0;
    t_fail   = '0;
    for (int i = 0; i < N; i++) begin
      t_finish[i] = spur_fin[i] | (!t_reset[i] && fin_at[i] >= 0 && mcnt[i] == fin_at[i]);
      t_fail[i]   = spur_fail[i] | (!t_reset[i] &&
                    ((fmode[i] == 1 && mcnt[i] == fin_at[i]) ||
                     (fmode[i] == 2 && mcnt[i] == fin_at[i] - 3)));
    end
  end

  // Records each completed low period of test_reset as (test, cycles low).
  always @(negedge clock) begin
    if (mon_en) begin
      if ($countones(~t_reset) > 1) multi_low <= 1;
      for (int i = 0; i < N; i++) begin
        if (!t_reset[i]) lowcnt[i] <= lowcnt[i] + 1;
        else if (lowcnt[i] != 0) begin
          rec_t r;
          r.idx = i;
          r.len = lowcnt[i];
          obs_q.push_back(r);
          lowcnt[i] <= 0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) lowcnt[i] <= 0;
    end
  end

  task automatic cfg(input int f0, f1, f2, f3, m0, m1, m2, m3);
    fin_at[0] = f0; fin_at[1] = f1; fin_at[2] = f2; fin_at[3] = f3;
    fmode[0]  = m0; fmode[1]  = m1; fmode[2]  = m2; fmode[3]  = m3;
  endtask

  // Expected low period: RUN cycles (finish count + 1, or TO) plus the NEXT cycle.
  task automatic push_exp();
    for (int i = 0; i < N; i++) begin
      rec_t r;
      r.idx = i;
      r.len = (fin_at[i] < 0) ? TO + 1 : fin_at[i] + 2;
      exp_q.push_back(r);
    end
  endtask

  task automatic test_reset();
    mon_en = 0;
    reset  = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if (t_reset !== 4'hF)     begin errors++; $display("FAIL rst_test_reset got=%h want=f", t_reset); end
    checks++; if (cur_test !== 2'd0)    begin errors++; $display("FAIL rst_cur_test got=%0d want=0", cur_test); end
    checks++; if (fail_mask !== 4'h0)   begin errors++; $display("FAIL rst_fail_mask got=%h want=0", fail_mask); end
    checks++; if (timeout_mask !== 4'h0) begin errors++; $display("FAIL rst_timeout_mask got=%h want=0", timeout_mask); end
    checks++; if (fail_count !== 3'd0)  begin errors++; $display("FAIL rst_fail_count got=%0d want=0", fail_count); end
    checks++; if (done !== 1'b0)        begin errors++; $display("FAIL rst_done got=%b want=0", done); end
    checks++; if (fail !== 1'b0)        begin errors++; $display("FAIL rst_fail got=%b want=0", fail); end
    exp_q.delete();
    obs_q.delete();
    multi_low = 0;
    reset     = 1'b0;
    mon_en    = 1;
  endtask

  task automatic wait_done(input string nm, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clock);
      cyc++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done_timeout got=%b want=1", nm, done); end
    @(negedge clock);
  endtask

  task automatic check_end(input string nm, input logic [N-1:0] efm, input logic [N-1:0] etm,
                           input logic [2:0] efc);
    checks++; if (fail_mask !== efm)    begin errors++; $display("FAIL %s_fail_mask got=%b want=%b", nm, fail_mask, efm); end
    checks++; if (timeout_mask !== etm) begin errors++; $display("FAIL %s_timeout_mask got=%b want=%b", nm, timeout_mask, etm); end
    checks++; if (fail_count !== efc)   begin errors++; $display("FAIL %s_fail_count got=%0d want=%0d", nm, fail_count, efc); end
    checks++; if (fail !== (efc != 0))  begin errors++; $display("FAIL %s_fail got=%b want=%b", nm, fail, efc != 0); end
    checks++; if (t_reset !== 4'hF)     begin errors++; $display("FAIL %s_done_resets got=%h want=f", nm, t_reset); end
    checks++; if (multi_low !== 0)      begin errors++; $display("FAIL %s_one_release got=%b want=0", nm, multi_low); end
    while (exp_q.size() != 0) begin
      rec_t e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL %s_run_missing got=none want=test%0d len%0d", nm, e.idx, e.len);
      end else begin
        rec_t o = obs_q.pop_front();
        if (o.idx !== e.idx || o.len !== e.len) begin
          errors++; $display("FAIL %s_run got=test%0d len%0d want=test%0d len%0d", nm, o.idx, o.len, e.idx, e.len);
        end
      end
    end
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL %s_extra_runs got=%0d want=0", nm, obs_q.size()); end
  endtask

  task automatic test_all_pass();
    int cyc;
    test_reset();
    cfg(3, 3, 3, 3, 0, 0, 0, 0);
    push_exp();
    wait_done("pass", cyc);
    checks++; if (cyc != N * (RC + 4 + 1)) begin errors++; $display("FAIL pass_latency got=%0d want=%0d", cyc, N * (RC + 5)); end
    check_end("pass", 4'b0000, 4'b0000, 3'd0);
  endtask

  task automatic test_fail_with_finish();
    int cyc;
    test_reset();
    cfg(3, 3, 3, 3, 0, 0, 1, 0);
    push_exp();
    wait_done("fail2", cyc);
    check_end("fail2", 4'b0100, 4'b0000, 3'd1);
  endtask

  task automatic test_sticky_fail();
    int cyc;
    test_reset();
    cfg(3, 6, 3, 3, 0, 2, 0, 0);
    push_exp();
    wait_done("sticky", cyc);
    check_end("sticky", 4'b0010, 4'b0000, 3'd1);
  endtask

  task automatic test_ignore_unselected();
    int cyc;
    int w;
    test_reset();
    cfg(3, 3, 3, 3, 0, 0, 0, 0);
    push_exp();
    w = 0;
    while (t_reset[0] !== 1'b0 && w < 100) begin @(negedge clock); w++; end
    checks++; if (t_reset[0] !== 1'b0) begin errors++; $display("FAIL ign_release got=%b want=0", t_reset[0]); end
    spur_fin[3]  = 1'b1;
    spur_fail[3] = 1'b1;
    repeat (2) @(negedge clock);
    spur_fin  = '0;
    spur_fail = '0;
    checks++; if (cur_test !== 2'd0 || t_reset[0] !== 1'b0) begin
      errors++; $display("FAIL ign_still_running got=cur%0d rst%b want=cur0 rst0", cur_test, t_reset[0]);
    end
    wait_done("ign", cyc);
    check_end("ign", 4'b0000, 4'b0000, 3'd0);
  endtask

`ifdef TEST_RUNNER_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    test_reset();
    cfg(3, -1, 3, 3, 0, 0, 0, 0);
    push_exp();
    wait_done("tmo", cyc);
    check_end("tmo", 4'b0010, 4'b0010, 3'd1);
  endtask
`endif

  task automatic test_mid_run_reset();
    int cyc;
    int w;
    test_reset();
    cfg(3, 3, 3, 3, 0, 0, 1, 0);
    w = 0;
    while (!(cur_test === 2'd2 && t_reset[2] === 1'b0) && w < 200) begin @(negedge clock); w++; end
    checks++; if (cur_test !== 2'd2) begin errors++; $display("FAIL mid_reach_test2 got=%0d want=2", cur_test); end
    @(negedge clock);
    test_reset();
    cfg(3, 3, 3, 3, 0, 0, 0, 0);
    push_exp();
    wait_done("mid", cyc);
    check_end("mid", 4'b0000, 4'b0000, 3'd0);
  endtask

  initial begin
    cfg(3, 3, 3, 3, 0, 0, 0, 0);
    test_all_pass();
    test_reset();
    test_fail_with_finish();
    test_sticky_fail();
    test_ignore_unselected();
`ifdef TEST_RUNNER_TIMEOUT_EN
    test_timeout();
`endif
    test_mid_run_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
